// File: rtl/dino_pkg.sv
// Shared definitions for the dino motion controller: state codes,
// score width and the default physics constants.
package dino_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_DUCK = 3'd1,
    ST_RISE = 3'd2,
    ST_HANG = 3'd3,
    ST_FALL = 3'd4,
    ST_DEAD = 3'd5
  } dino_state_t;

  localparam int SCORE_W        = 14;
  localparam int Y_W_DEF        = 8;
  localparam int JUMP_V0_DEF    = 12;
  localparam int GRAVITY_DEF    = 1;
  localparam int HANG_TICKS_DEF = 2;
  localparam int SCORE_MAX_DEF  = 9999;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: remembers the previous sample of sig and flags
// the clock in which sig is high but was low one clock earlier.
// RESET_VAL chooses the assumed previous level after reset.
module edge_rise_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev;

  // Previous-sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= RESET_VAL;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino motion controller: turns game_tick rising edges into game steps and
// runs the run/duck/jump/dead FSM, vertical physics, leg animation and score.
// Handshake note: there is no valid/ready pairing here; step is a one-clk
// strobe and every other output is a level that is valid on every clock.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int Y_W        = Y_W_DEF,
  parameter int JUMP_V0    = JUMP_V0_DEF,
  parameter int GRAVITY    = GRAVITY_DEF,
  parameter int HANG_TICKS = HANG_TICKS_DEF,
  parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               jump_btn,
  input  logic               duck_btn,
  input  logic               hit,
  input  logic               restart,
  output logic               step,
  output logic [Y_W-1:0]     dino_y,
  output logic [2:0]         state,
  output logic               ducking,
  output logic               airborne,
  output logic               dead,
  output logic               leg_frame,
  output logic [SCORE_W-1:0] score
);

  localparam int VEL_W  = $clog2(JUMP_V0) + 1;
  localparam int VS_W   = VEL_W + 1;
  localparam int HANG_W = (HANG_TICKS < 2) ? 1 : $clog2(HANG_TICKS + 1);

  logic tick_rise, jump_rise, restart_rise;

  // The tick history starts high so a tick already high at reset release
  // is not mistaken for a fresh edge.
  edge_rise_det #(.RESET_VAL(1'b1)) u_tick_edge (
    .clk(clk), .rst(rst), .sig(game_tick), .rise(tick_rise)
  );
  edge_rise_det #(.RESET_VAL(1'b0)) u_jump_edge (
    .clk(clk), .rst(rst), .sig(jump_btn), .rise(jump_rise)
  );
  edge_rise_det #(.RESET_VAL(1'b0)) u_restart_edge (
    .clk(clk), .rst(rst), .sig(restart), .rise(restart_rise)
  );

  dino_state_t        state_q, state_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [VEL_W-1:0]   vel_q, vel_d;
  logic [HANG_W-1:0]  hang_q, hang_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               leg_q, leg_d;
  logic               jump_req_q, jump_req_d;
  logic               step_q;

  // Falling speed for this step, capped at the launch speed
  logic [VS_W-1:0]  fall_sum;
  logic [VEL_W-1:0] fall_vel;
  assign fall_sum = {1'b0, vel_q} + (duck_btn ? VS_W'(2 * GRAVITY) : VS_W'(GRAVITY));
  assign fall_vel = (fall_sum > VS_W'(JUMP_V0)) ? VEL_W'(JUMP_V0) : fall_sum[VEL_W-1:0];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      y_q        <= '0;
      vel_q      <= '0;
      hang_q     <= '0;
      score_q    <= '0;
      leg_q      <= 1'b0;
      jump_req_q <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      hang_q     <= hang_d;
      score_q    <= score_d;
      leg_q      <= leg_d;
      jump_req_q <= jump_req_d;
      step_q     <= tick_rise;
    end
  end

  // Next-state, physics, score and animation
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    vel_d      = vel_q;
    hang_d     = hang_q;
    score_d    = score_q;
    leg_d      = leg_q;
    jump_req_d = jump_req_q;

    // Jump presses only count on the ground; airborne presses are dropped
    if (jump_rise && (state_q == ST_RUN || state_q == ST_DUCK)) jump_req_d = 1'b1;

    if (state_q == ST_DEAD) begin
      // hit is ignored here, so restart wins over a simultaneous hit
      if (restart_rise) begin
        state_d    = ST_RUN;
        y_d        = '0;
        vel_d      = '0;
        hang_d     = '0;
        score_d    = '0;
        leg_d      = 1'b0;
        jump_req_d = 1'b0;
      end
    end else if (hit) begin
      // Collision freezes position, score and animation on any clock
      state_d    = ST_DEAD;
      jump_req_d = 1'b0;
    end else if (step_q) begin
      if (score_q < SCORE_W'(SCORE_MAX)) score_d = score_q + 1'b1;
      case (state_q)
        ST_RUN, ST_DUCK: begin
          leg_d = ~leg_q;
          if (jump_req_q) begin
            state_d    = ST_RISE;
            vel_d      = VEL_W'(JUMP_V0);
            jump_req_d = 1'b0;
          end else if (state_q == ST_RUN && duck_btn) begin
            state_d = ST_DUCK;
          end else if (state_q == ST_DUCK && !duck_btn) begin
            state_d = ST_RUN;
          end
        end
        ST_RISE: begin
          if (duck_btn) begin
            state_d = ST_FALL;
            vel_d   = '0;
          end else begin
            y_d = y_q + Y_W'(vel_q);
            if (vel_q <= VEL_W'(GRAVITY)) begin
              vel_d   = '0;
              state_d = ST_HANG;
              hang_d  = '0;
            end else begin
              vel_d = vel_q - VEL_W'(GRAVITY);
            end
          end
        end
        ST_HANG: begin
          if (duck_btn) begin
            state_d = ST_FALL;
            vel_d   = '0;
          end else begin
            hang_d = hang_q + HANG_W'(1);
            if (hang_q + HANG_W'(1) == HANG_W'(HANG_TICKS)) begin
              state_d = ST_FALL;
              vel_d   = '0;
            end
          end
        end
        ST_FALL: begin
          vel_d = fall_vel;
          if (y_q <= Y_W'(fall_vel)) begin
            y_d     = '0;
            state_d = ST_RUN;
          end else begin
            y_d = y_q - Y_W'(fall_vel);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign step      = step_q;
  assign dino_y    = y_q;
  assign state     = state_q;
  assign ducking   = (state_q == ST_DUCK);
  assign airborne  = (state_q == ST_RISE) || (state_q == ST_HANG) || (state_q == ST_FALL);
  assign dead      = (state_q == ST_DEAD);
  assign leg_frame = leg_q;
  assign score     = score_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl. Expected per-step snapshots
// {state, dino_y, score, leg_frame} are queued as ticks are driven; a monitor
// queues the DUT snapshot after every step pulse and each test drains both.
module tb_dino_motion_ctrl;

  localparam logic [2:0] S_RUN = 3'd0, S_DUCK = 3'd1, S_RISE = 3'd2,
                         S_HANG = 3'd3, S_FALL = 3'd4, S_DEAD = 3'd5;
  localparam int W = 26;

  logic        clk, rst, game_tick, jump_btn, duck_btn, hit, restart;
  logic        step, ducking, airborne, dead, leg_frame;
  logic [7:0]  dino_y;
  logic [2:0]  state;
  logic [13:0] score;

  dino_motion_ctrl dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .jump_btn(jump_btn),
    .duck_btn(duck_btn), .hit(hit), .restart(restart), .step(step),
    .dino_y(dino_y), .state(state), .ducking(ducking), .airborne(airborne),
    .dead(dead), .leg_frame(leg_frame), .score(score)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] e, o;
  int n_checks = 0, n_fail = 0, step_cnt = 0;
  logic step_seen = 1'b0;

  logic [2:0]  exp_state = S_RUN;
  logic [7:0]  exp_y = 8'd0;
  logic [13:0] exp_score = 14'd0;
  logic        exp_leg = 1'b0;

  // Full jump trajectory after the launch step
  int jump_y[27] = '{0, 12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78, 78,
                     77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
  logic [2:0] jump_s[27] = '{S_RISE, S_RISE, S_RISE, S_RISE, S_RISE, S_RISE,
                             S_RISE, S_RISE, S_RISE, S_RISE, S_RISE, S_RISE,
                             S_HANG, S_HANG, S_FALL, S_FALL, S_FALL, S_FALL,
                             S_FALL, S_FALL, S_FALL, S_FALL, S_FALL, S_FALL,
                             S_FALL, S_FALL, S_RUN};

  // Monitor: snapshot outputs one clock after each step pulse
  always @(negedge clk) begin
    if (rst) begin
      step_seen = 1'b0;
    end else begin
      if (step_seen) obs_q.push_back({state, dino_y, score, leg_frame});
      if (step) step_cnt++;
      step_seen = step;
    end
  end

  // One game-tick period: low then high, half clocks each
  task automatic tick_step(input int half);
    game_tick = 1'b0;
    repeat (half) @(negedge clk);
    game_tick = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Expected effect of one step landing in state st at height y
  task automatic push_exp(input logic [2:0] st, input int y);
    if (exp_state != S_DEAD) begin
      if (exp_state == S_RUN || exp_state == S_DUCK) exp_leg = ~exp_leg;
      if (exp_score < 14'd9999) exp_score = exp_score + 14'd1;
    end
    exp_state = st;
    exp_y = 8'(y);
    exp_q.push_back({st, exp_y, exp_score, exp_leg});
  endtask

  task automatic pulse_jump();
    @(negedge clk) jump_btn = 1'b1;
    @(negedge clk) jump_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; game_tick = 1'b1; jump_btn = 1'b0; duck_btn = 1'b0;
    hit = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({state, dino_y, score, leg_frame, step, dead} !== {S_RUN, 8'd0, 14'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: state=%0d y=%0d score=%0d leg=%0d step=%0d dead=%0d, want all 0", state, dino_y, score, leg_frame, step, dead);
    end
  endtask

  task automatic test_step_gen();
    rst = 1'b0;
    step_cnt = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (step_cnt !== 0) begin
      n_fail++;
      $display("FAIL no_step_on_release: steps=%0d want 0", step_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick_step(4);
      push_exp(S_RUN, 0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (step_cnt !== 3) begin
      n_fail++;
      $display("FAIL step_count: steps=%0d want 3", step_cnt);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL step_gen_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL step_gen: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_jump();
    pulse_jump();
    for (int i = 0; i < 27; i++) begin
      tick_step(4);
      push_exp(jump_s[i], jump_y[i]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL jump_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL jump: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_jump_in_hang();
    pulse_jump();
    for (int i = 0; i < 27; i++) begin
      tick_step(4);
      push_exp(jump_s[i], jump_y[i]);
      if (i == 12) pulse_jump();
    end
    for (int i = 0; i < 3; i++) begin
      tick_step(4);
      push_exp(S_RUN, 0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL hang_jump_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL hang_jump: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_duck_fall();
    int fy[6] = '{33, 31, 27, 21, 13, 3};
    pulse_jump();
    tick_step(4); push_exp(S_RISE, 0);
    tick_step(4); push_exp(S_RISE, 12);
    tick_step(4); push_exp(S_RISE, 23);
    tick_step(4); push_exp(S_RISE, 33);
    duck_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_step(4);
      push_exp(S_FALL, fy[i]);
    end
    tick_step(4); push_exp(S_RUN, 0);
    tick_step(4); push_exp(S_DUCK, 0);
    n_checks++;
    if (ducking !== 1'b1) begin n_fail++; $display("FAIL ducking_flag: got %0d want 1", ducking); end
    duck_btn = 1'b0;
    tick_step(4); push_exp(S_RUN, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL duck_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL duck_fall: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_hit_dead();
    pulse_jump();
    tick_step(4); push_exp(S_RISE, 0);
    tick_step(4); push_exp(S_RISE, 12);
    tick_step(4); push_exp(S_RISE, 23);
    tick_step(4); push_exp(S_RISE, 33);
    tick_step(4); push_exp(S_RISE, 42);
    tick_step(4); push_exp(S_RISE, 50);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    n_checks++;
    if ({dead, state, dino_y, airborne} !== {1'b1, S_DEAD, 8'd50, 1'b0}) begin
      n_fail++;
      $display("FAIL hit_dead: dead=%0d state=%0d y=%0d air=%0d, want 1 5 50 0", dead, state, dino_y, airborne);
    end
    exp_state = S_DEAD;
    for (int i = 0; i < 5; i++) begin
      tick_step(4);
      push_exp(S_DEAD, 50);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL dead_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL hit_freeze: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_restart_hit();
    restart = 1'b1; hit = 1'b1;
    @(negedge clk);
    restart = 1'b0; hit = 1'b0;
    n_checks++;
    if ({state, dino_y, score, leg_frame, dead} !== {S_RUN, 8'd0, 14'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL restart: state=%0d y=%0d score=%0d leg=%0d dead=%0d, want 0 0 0 0 0", state, dino_y, score, leg_frame, dead);
    end
    exp_state = S_RUN; exp_y = 8'd0; exp_score = 14'd0; exp_leg = 1'b0;
    tick_step(4); push_exp(S_RUN, 0);
    tick_step(4); push_exp(S_RUN, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL restart_run: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    pulse_jump();
    for (int i = 0; i < 4; i++) tick_step(4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({state, dino_y, score, leg_frame} !== {S_RUN, 8'd0, 14'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d y=%0d score=%0d leg=%0d, want 0 0 0 0", state, dino_y, score, leg_frame);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); obs_q.delete();
    exp_state = S_RUN; exp_y = 8'd0; exp_score = 14'd0; exp_leg = 1'b0;
  endtask

  task automatic test_score_sat();
    for (int i = 0; i < 9998; i++) begin
      tick_step(1);
      push_exp(S_RUN, 0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (score !== 14'd9998) begin n_fail++; $display("FAIL score_9998: got %0d want 9998", score); end
    for (int i = 0; i < 3; i++) begin
      tick_step(2);
      push_exp(S_RUN, 0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (score !== 14'd9999) begin n_fail++; $display("FAIL score_sat: got %0d want 9999", score); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL score_run: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_step_gen();
    test_jump();
    test_jump_in_hang();
    test_duck_fall();
    test_hit_dead();
    test_restart_hit();
    test_async_reset();
    test_score_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dino_motion_ctrl.md
Name: dino_motion_ctrl

Overview:
- Consumes the accelerating game-tick square wave from the game clock divider and turns each rising edge into one game step.
- Runs the dino's run/jump/duck/dead state machine, vertical physics, leg animation and the score counter.
- Feeds the renderer (dino_y, leg_frame, ducking) and the HUD (score, dead).
- Re-exports the step strobe for the obstacle scroller.

Parameters:
- Y_W, 8, width of dino_y (height above ground, pixels).
- JUMP_V0, 12, launch velocity in px/step. Constraint: JUMP_V0*(JUMP_V0+1)/2 < 2^Y_W.
- GRAVITY, 1, velocity change per step.
- HANG_TICKS, 2, steps held at apex.
- SCORE_MAX, 9999, score saturation value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- game_tick  in  1  divided game clock; square wave, clk-synchronous.
- jump_btn  in  1  debounced jump button, level.
- duck_btn  in  1  debounced duck button, level.
- hit  in  1  collision flag from the collision checker, level.
- restart  in  1  restart request, level; edge-detected internally.
- step  out  1  one-clk pulse per rising edge of game_tick.
- dino_y  out  Y_W  dino height above ground.
- state  out  3  FSM state code.
- ducking  out  1  high in DUCK.
- airborne  out  1  high in RISE/HANG/FALL.
- dead  out  1  high in DEAD.
- leg_frame  out  1  run animation phase.
- score  out  14  steps survived, binary.

Behaviour:

Reset values:
- state=RUN, dino_y=0, vel=0, hang_cnt=0, score=0, leg_frame=0, step=0, jump_req=0.
- game_tick previous-sample register resets to 1, so no spurious step occurs on reset release when the tick is high.
- jump_btn and restart previous-sample registers reset to 0.

Step generation:
- step = game_tick & ~tick_prev, registered. step is high exactly one clk, one clk after the rising edge.
- All physics updates happen on step cycles only.

Jump request:
- A rising edge of jump_btn in RUN or DUCK sets jump_req.
- Edges in any other state are discarded; there is no airborne buffering.
- jump_req clears when consumed, or on entry to DEAD.

FSM, evaluated on step unless noted:
- RUN:
  - If jump_req: go to RISE, vel=JUMP_V0, dino_y stays 0, clear jump_req.
  - Else if duck_btn: go to DUCK.
- DUCK:
  - If jump_req: go to RISE, same as from RUN.
  - Else if !duck_btn: go to RUN.
- RISE:
  - If duck_btn: go to FALL, vel=0, dino_y unchanged.
  - Else: dino_y += vel, vel -= GRAVITY. When the new vel is 0, go to HANG with hang_cnt=0.
- HANG:
  - If duck_btn: go to FALL, vel=0.
  - Else: hang_cnt++. When it reaches HANG_TICKS, go to FALL with vel=0.
- FALL:
  - vel = min(vel + (duck_btn ? 2*GRAVITY : GRAVITY), JUMP_V0).
  - If dino_y <= new vel: dino_y=0 and go to RUN.
  - Else: dino_y -= new vel.
- DEAD: outputs frozen; step is still emitted.
- Any non-DEAD state, with hit=1 on any clk (not only step cycles): go to DEAD that clk. dino_y, score and leg_frame hold.
- DEAD, on a restart rising edge: go to RUN with dino_y=0, vel=0, score=0, leg_frame=0. hit is ignored in DEAD, so a simultaneous hit and restart means restart wins.
- A restart edge outside DEAD is ignored.

Score and animation:
- score increments on each step while not DEAD, and saturates at SCORE_MAX.
- A step that coincides with the hit clk does not increment.
- leg_frame toggles on step in RUN and DUCK, and holds in other states.

Arithmetic:
- vel is an unsigned register, width clog2(JUMP_V0)+1.
- Landing clamps at 0; dino_y never underflows.

Mid-operation reset: rst at any time returns all state asynchronously to the reset values.

Decomposition:
- Shared package dino_pkg holds:
  - state codes RUN=0, DUCK=1, RISE=2, HANG=3, FALL=4, DEAD=5;
  - SCORE_W=14;
  - the default physics constants.
- One sub-module, edge_rise_det (param RESET_VAL), with one instance each for game_tick, jump_btn and restart.

Test Plan:
- Hold game_tick high across reset release, then toggle it at period 8 clk -> no step on release; one step per rising edge; score=1 after the first edge.
- jump_btn pulse in RUN, then steps:
  - RISE for 12 steps, dino_y = 12, 23, 33, … 78;
  - HANG for 2 steps at 78;
  - FALL for 12 steps, 77, 75, … 0;
  - then RUN.
- jump_btn pulse while in HANG -> ignored; exactly one jump occurs and RUN is reached with jump_req=0.
- duck_btn held from step 3 of RISE (dino_y=33) -> FALL with vel +2 per step: 31, 27, 21, 13, 3, 0 -> RUN, then DUCK while duck_btn is still held.
- hit at dino_y=50 between steps -> dead=1 next clk; dino_y=50 and score frozen over 5 further steps.
- restart and hit asserted on the same clk while DEAD -> RUN, score=0, dino_y=0.
- Force score to 9998 -> after 3 steps it reads 9999.
